// File: rtl/tvip_common_pkg.sv
// Types and helpers shared by the tvip APB completer and its RAM.
package tvip_common_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } tvip_apb_state_e;

  localparam int unsigned TVIP_MAX_WAIT_CYCLES = 15;

  // Number of paddr bits that select a byte within one data word.
  function automatic int unsigned byte_offset_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/tvip_byte_enable_ram.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables, asynchronous read,
// and a sequencer that zeroes every word after reset release.
module tvip_byte_enable_ram #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       init_done
);

  localparam int ADDR_BITS  = $clog2(DEPTH);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_BITS-1:0] LAST_INDEX = ADDR_BITS'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  init_idx;

  // The array has no reset of its own; this walks one word per cycle so that
  // reads after initialisation return zero for never-written locations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_idx  <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      init_idx <= init_idx + ADDR_BITS'(1);
      if (init_idx == LAST_INDEX) begin
        init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!init_done) begin
      mem[init_idx] <= '0;
    end else begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tvip_apb_slave_ram.sv
// APB4 completer backed by a byte-enable RAM: fixed wait states, registered
// outputs, and an error response for misaligned or out-of-range addresses.
module tvip_apb_slave_ram
  import tvip_common_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 256,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr
);

  localparam int STRB_WIDTH    = DATA_WIDTH / 8;
  localparam int OFFSET_BITS   = byte_offset_bits(DATA_WIDTH);
  localparam int RAM_ADDR_BITS = $clog2(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'((1 << OFFSET_BITS) - 1);
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]               WAIT_LOAD   = 4'(WAIT_CYCLES);

  tvip_apb_state_e state_q, state_n;
  logic [3:0]      cnt_q, cnt_n;
  logic            capture;

  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_WIDTH-1:0]    strb_q;
  logic                     err_q;

  logic                     pready_n;
  logic                     pslverr_n;
  logic [DATA_WIDTH-1:0]    prdata_n;

  logic [ADDRESS_WIDTH-1:0] req_word;
  logic                     req_err;
  logic [RAM_ADDR_BITS-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0]    ram_rdata;
  logic [STRB_WIDTH-1:0]    ram_wstrb;
  logic                     init_done;
  logic                     unused_pprot;

  assign unused_pprot = ^pprot;

  assign req_word = paddr >> OFFSET_BITS;
  assign req_err  = (|(paddr & OFFSET_MASK)) || ({1'b0, req_word} >= DEPTH_LIMIT);

  // With zero wait states the response is registered at the capture edge,
  // so the RAM must be read at the live bus address while still idle.
  assign ram_raddr = (state_q == IDLE) ? req_word[RAM_ADDR_BITS-1:0] : addr_q;

  tvip_byte_enable_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk       (pclk),
    .rst_n     (presetn),
    .waddr     (addr_q),
    .wdata     (wdata_q),
    .wstrb     (ram_wstrb),
    .raddr     (ram_raddr),
    .rdata     (ram_rdata),
    .init_done (init_done)
  );

  // Outputs are computed one cycle ahead: the *_n values describe the cycle
  // that follows the next edge, which keeps every output a plain flop.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    capture   = 1'b0;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    prdata_n  = '0;
    ram_wstrb = '0;

    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (psel && !penable) begin
          capture = 1'b1;
          state_n = SETUP;
          cnt_n   = WAIT_LOAD;
          if (WAIT_LOAD == 4'd0 && init_done) begin
            pready_n  = 1'b1;
            pslverr_n = req_err;
            prdata_n  = (!pwrite && !req_err) ? ram_rdata : '0;
          end
        end
      end
      SETUP, ACCESS: begin
        if (!psel) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (pready) begin
          state_n = IDLE;
          cnt_n   = '0;
          if (write_q && !err_q) begin
            ram_wstrb = strb_q;
          end
        end else begin
          state_n = ACCESS;
          if (cnt_q != 4'd0) begin
            cnt_n = cnt_q - 4'd1;
          end
          // Completion is also held off until the RAM clear has finished.
          if (cnt_n == 4'd0 && init_done) begin
            pready_n  = 1'b1;
            pslverr_n = err_q;
            prdata_n  = (!write_q && !err_q) ? ram_rdata : '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pready  <= pready_n;
      prdata  <= prdata_n;
      pslverr <= pslverr_n;
      if (capture) begin
        addr_q  <= req_word[RAM_ADDR_BITS-1:0];
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        err_q   <= req_err;
      end
    end
  end

endmodule

// File: tb/tb_tvip_apb_slave_ram.sv
// Scoreboard bench for tvip_apb_slave_ram: one instance with no wait states
// and one with three, both checked against a word-array model of the RAM.
module tb_tvip_apb_slave_ram;

  localparam int DEPTH = 256;

  typedef struct {
    int          dut;
    bit          write;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [15:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [2:0]  pprot   [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];

  logic [31:0] model_mem [2][DEPTH];
  exp_t        exp_q [$];
  int          check_count = 0;
  int          error_count = 0;

  always #5 pclk = ~pclk;

  tvip_apb_slave_ram #(
    .ADDRESS_WIDTH (16), .DATA_WIDTH (32), .DEPTH (DEPTH), .WAIT_CYCLES (0)
  ) dut_w0 (
    .pclk (pclk), .presetn (presetn), .psel (psel[0]), .penable (penable[0]),
    .pwrite (pwrite[0]), .paddr (paddr[0]), .pwdata (pwdata[0]), .pstrb (pstrb[0]),
    .pprot (pprot[0]), .pready (pready[0]), .prdata (prdata[0]), .pslverr (pslverr[0])
  );

  tvip_apb_slave_ram #(
    .ADDRESS_WIDTH (16), .DATA_WIDTH (32), .DEPTH (DEPTH), .WAIT_CYCLES (3)
  ) dut_w3 (
    .pclk (pclk), .presetn (presetn), .psel (psel[1]), .penable (penable[1]),
    .pwrite (pwrite[1]), .paddr (paddr[1]), .pwdata (pwdata[1]), .pstrb (pstrb[1]),
    .pprot (pprot[1]), .pready (pready[1]), .prdata (prdata[1]), .pslverr (pslverr[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearModels();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        model_mem[d][i] = 32'h0;
  endtask

  // Issues one transfer starting at posedge+1 and returns at posedge+1 after
  // the completion edge; the expected response is queued for the monitor.
  task automatic applyStimulus(input int d, input bit wr, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input bit keep_sel, input bit reset_at_done);
    exp_t e;
    int   cycles;
    bit   done;
    bit   err;
    int   idx;
    idx     = int'(addr >> 2);
    err     = (addr[1:0] != 2'b00) || (idx >= DEPTH);
    e.dut   = d;
    e.write = wr;
    e.err   = err;
    e.rdata = (!wr && !err) ? model_mem[d][idx] : 32'h0;
    exp_q.push_back(e);
    if (wr && !err)
      for (int i = 0; i < 4; i++)
        if (strb[i]) model_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];

    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    pstrb[d]   = strb;
    pprot[d]   = 3'($urandom_range(0, 7));
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    cycles = 1;
    done   = 1'b0;
    while (!done && cycles < 64) begin
      @(negedge pclk);
      cycles++;
      if (pready[d]) begin
        done = 1'b1;
        if (reset_at_done) begin
          #1 presetn = 1'b0;
          #1;
          checkOutput("reset_pready", 32'(pready[d]), 32'd0);
          checkOutput("reset_prdata", prdata[d], 32'd0);
          checkOutput("reset_pslverr", 32'(pslverr[d]), 32'd0);
        end
      end
      if (!(done && reset_at_done)) begin
        @(posedge pclk); #1;
      end
    end
    checkOutput("completed", 32'(done), 32'd1);
    if (done) checkOutput("latency", cycles, 32'(2 + wait_of(d)));
    if (!keep_sel || reset_at_done || !done) begin
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
    end
  endtask

  // Write that the requester abandons mid-ACCESS; the model is left untouched.
  task automatic applyAbort(input int d, input logic [15:0] addr, input logic [31:0] wdata);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b1;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    pstrb[d]   = 4'hF;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    @(negedge pclk);
    checkOutput("abort_pready_low", 32'(pready[d]), 32'd0);
    @(posedge pclk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      checkOutput("abort_no_pready", 32'(pready[d]), 32'd0);
    end
    @(posedge pclk); #1;
  endtask

  always @(negedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      if (pready[d]) begin
        if (psel[d] && penable[d]) begin
          if (exp_q.size() == 0) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL unexpected_completion dut=%0d actual=pready required=no_pending", d);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("dut_select", 32'(d), 32'(e.dut));
            checkOutput("pslverr", 32'(pslverr[d]), 32'(e.err));
            if (!e.write) checkOutput("prdata", prdata[d], e.rdata);
          end
        end else begin
          checkOutput("spurious_pready", 32'(pready[d]), 32'd0);
        end
      end else begin
        checkOutput("idle_prdata", prdata[d], 32'd0);
      end
    end
  end

  initial begin
    int          r;
    int          idx;
    logic [15:0] addr;
    bit          keep;

    presetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0;
      pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_pready", 32'(pready[d]), 32'd0);
      checkOutput("rst_prdata", prdata[d], 32'd0);
      checkOutput("rst_pslverr", 32'(pslverr[d]), 32'd0);
    end
    @(posedge pclk); #1 presetn = 1'b1;
    repeat (DEPTH + 8) @(posedge pclk);
    #1;
    clearModels();

    for (int d = 0; d < 2; d++) begin
      $display("[TB] directed sequence on instance with %0d wait cycles", wait_of(d));
      applyStimulus(d, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(d, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
      applyStimulus(d, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(d, 1'b1, 16'h0020, 32'h11223344, 4'hF, 1'b0, 1'b0);
      applyStimulus(d, 1'b1, 16'h0020, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0);
      applyStimulus(d, 1'b0, 16'h0020, 32'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(d, 1'b0, 16'h0401, 32'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(d, 1'b0, 16'h0400, 32'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(d, 1'b1, 16'h0002, 32'h55555555, 4'hF, 1'b0, 1'b0);
      applyStimulus(d, 1'b1, 16'h0400, 32'h66666666, 4'hF, 1'b0, 1'b0);
      applyStimulus(d, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
        applyStimulus(d, 1'b1, 16'(16'h0080 + 4 * i), $urandom, 4'hF, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
        applyStimulus(d, 1'b0, 16'(16'h0080 + 4 * i), 32'h0, 4'h0, i != 3, 1'b0);

      for (int n = 0; n < 30; n++) begin
        r    = $urandom_range(0, 7);
        idx  = $urandom_range(0, 15);
        addr = 16'(16'h0040 + 4 * idx);
        if (r == 0) addr = addr + 16'($urandom_range(1, 3));
        else if (r == 1) addr = 16'(16'h0400 + 4 * idx);
        keep = ($urandom_range(0, 1) == 1) && (n != 29);
        applyStimulus(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), keep, 1'b0);
        if (!keep) repeat ($urandom_range(0, 2)) begin
          @(posedge pclk); #1;
        end
      end
    end

    $display("[TB] abort and reset sequence");
    applyAbort(1, 16'h0010, 32'hCAFEF00D);
    applyStimulus(1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 16'h0020, 32'h0, 4'h0, 1'b0, 1'b1);
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    repeat (DEPTH + 8) @(posedge pclk);
    #1;
    clearModels();
    applyStimulus(1, 1'b0, 16'h0020, 32'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 1'b0);

    repeat (3) @(negedge pclk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
